// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
package riscv_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALRA,
        S_JALRJ,
        S_LUI,
        S_AUIPC,
        S_MDEXEC,
        S_MDWB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_MD     = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            OP_LUI, OP_AUIPC:  return IMM_U;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/instr_legal_chk.sv
// Combinational legality check of the latched instruction fields.
module instr_legal_chk
    import riscv_ctrl_pkg::*;
#(
    parameter bit M_EXT = 1'b0
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b0,
    output logic       legal
);

    // Flag unknown opcodes and reserved funct3 encodings of known ones.
    always_comb begin
        legal = 1'b1;
        case (op)
            OP_LOAD:   legal = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
            OP_STORE:  legal = (funct3 <= 3'b010);
            OP_BRANCH: legal = !(funct3 == 3'b010 || funct3 == 3'b011);
            OP_R:      legal = !(funct7b0 && !M_EXT);
            OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute over a shared memory
// with wait states, optional mul/div sequencing and illegal-instruction trap.
//
// state    | meaning
// FETCH    | read instruction; latch IR and PC+4 on ready
// DECODE   | read registers, branch target into ALUOut, dispatch
// MEMADR   | compute load/store address
// MEMREAD  | load access, wait for ready
// MEMWB    | write load data to register file
// MEMWRITE | store access, strobe on ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to register file
// BRANCH   | compare, redirect PC if taken
// JAL      | PC <= target, ALUOut <= OldPC+4
// JALRA    | rs1+imm into ALUOut
// JALRJ    | PC <= ALUOut, ALUOut <= OldPC+4
// LUI      | 0+imm
// AUIPC    | OldPC+imm
// MDEXEC   | mul/div running, pulse start on entry
// MDWB     | write mul/div result
// TRAP     | illegal instruction, halted until reset
module multicycle_controller #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit M_EXT       = 1'b0,
    parameter bit TRAP_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    input  logic       br_taken,
    input  logic       mem_ready,
    input  logic       md_done,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       md_start,
    output logic       illegal
);
    import riscv_ctrl_pkg::*;

    state_t state, next_state;
    logic   md_busy;
    logic   legal;
    logic   ready;
    logic   mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s, md_start_s;

    // IR[30] is consumed by the downstream ALU decoder, not by this FSM.
    logic unused_funct7b5;
    assign unused_funct7b5 = funct7b5;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    instr_legal_chk #(.M_EXT(M_EXT)) u_legal (
        .op       (op),
        .funct3   (funct3),
        .funct7b0 (funct7b0),
        .legal    (legal)
    );

    // State register; md_busy marks MDEXEC cycles after the first so start pulses once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            md_busy <= 1'b0;
        end else begin
            state   <= next_state;
            md_busy <= (state == S_MDEXEC) && (next_state == S_MDEXEC);
        end
    end

    // Next-state sequencing.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (ready) next_state = S_DECODE;
            S_DECODE: begin
                if (!legal) begin
                    next_state = TRAP_EN ? S_TRAP : S_FETCH;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: next_state = S_MEMADR;
                        OP_R:              next_state = funct7b0 ? S_MDEXEC : S_EXECR;
                        OP_I:              next_state = S_EXECI;
                        OP_BRANCH:         next_state = S_BRANCH;
                        OP_JAL:            next_state = S_JAL;
                        OP_JALR:           next_state = S_JALRA;
                        OP_LUI:            next_state = S_LUI;
                        OP_AUIPC:          next_state = S_AUIPC;
                        default:           next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (ready) next_state = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_JALRJ, S_LUI, S_AUIPC: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JALRA:    next_state = S_JALRJ;
            S_MDEXEC:   if (md_done) next_state = S_MDWB;
            S_MDWB:     next_state = S_FETCH;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    // Datapath selects and raw strobes per state.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        md_start_s  = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_ADD;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_s  = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURES;
                ir_write_s = ready;
                pc_write_s = ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = RES_RDATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                AdrSrc      = 1'b1;
                mem_write_s = ready;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc   = RES_ALUOUT;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALUOP_BR;
                ResultSrc  = RES_ALUOUT;
                pc_write_s = br_taken;
            end
            S_JAL, S_JALRJ: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                pc_write_s = 1'b1;
            end
            S_JALRA: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MDEXEC: md_start_s = !md_busy;
            S_MDWB: begin
                ResultSrc   = RES_MD;
                reg_write_s = 1'b1;
            end
            S_TRAP:   illegal = 1'b1;
            default: ;
        endcase
    end

    // Strobes are masked by reset so an interrupted access drops without waiting for a clock.
    assign mem_req  = mem_req_s   & ~reset;
    assign MemWrite = mem_write_s & ~reset;
    assign IRWrite  = ir_write_s  & ~reset;
    assign PCWrite  = pc_write_s  & ~reset;
    assign RegWrite = reg_write_s & ~reset;
    assign md_start = md_start_s  & ~reset;
    assign ImmSrc   = imm_sel(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected output vectors are queued
// as each step is driven and compared when the cycle is sampled.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset0 = 1'b1;
    logic       reset1 = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       funct7b0 = 1'b0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       md_done = 1'b0;

    logic       mem_req_0, mw_0, irw_0, pcw_0, adr_0, rw_0, mds_0, ill_0;
    logic [1:0] rs_0, sa_0, sb_0, aop_0;
    logic [2:0] imm_0;
    logic       mem_req_1, mw_1, irw_1, pcw_1, adr_1, rw_1, mds_1, ill_1;
    logic [1:0] rs_1, sa_1, sb_1, aop_1;
    logic [2:0] imm_1;

    int total = 0;
    int bad   = 0;

    logic [18:0] exp_q[$];
    string       tag_q[$];
    bit          sel_q[$];

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RR  = 7'b0110011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] BAD = 7'b1111111;

    always #5 clk = ~clk;

    // u0: wait states honoured, no M extension, trapping
    multicycle_controller #(.MEM_WAIT_EN(1'b1), .M_EXT(1'b0), .TRAP_EN(1'b1)) u0 (
        .clk(clk), .reset(reset0), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .br_taken(br_taken), .mem_ready(mem_ready), .md_done(md_done),
        .mem_req(mem_req_0), .MemWrite(mw_0), .IRWrite(irw_0), .PCWrite(pcw_0), .AdrSrc(adr_0),
        .RegWrite(rw_0), .ResultSrc(rs_0), .ALUSrcA(sa_0), .ALUSrcB(sb_0), .ALUOp(aop_0),
        .ImmSrc(imm_0), .md_start(mds_0), .illegal(ill_0));

    // u1: zero-wait memory, M extension, illegal treated as NOP
    multicycle_controller #(.MEM_WAIT_EN(1'b0), .M_EXT(1'b1), .TRAP_EN(1'b0)) u1 (
        .clk(clk), .reset(reset1), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .br_taken(br_taken), .mem_ready(mem_ready), .md_done(md_done),
        .mem_req(mem_req_1), .MemWrite(mw_1), .IRWrite(irw_1), .PCWrite(pcw_1), .AdrSrc(adr_1),
        .RegWrite(rw_1), .ResultSrc(rs_1), .ALUSrcA(sa_1), .ALUSrcB(sb_1), .ALUOp(aop_1),
        .ImmSrc(imm_1), .md_start(mds_1), .illegal(ill_1));

    function automatic logic [18:0] ev(input logic mr, mw, irw, pcw, adr, rw,
                                       input logic [1:0] rs, sa, sb, aop,
                                       input logic [2:0] imm, input logic mds, ill);
        return {mr, mw, irw, pcw, adr, rw, rs, sa, sb, aop, imm, mds, ill};
    endfunction

    function automatic logic [18:0] e_fetch(input logic rdy, input logic [2:0] imm);
        return ev(1, 0, rdy, rdy, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0);
    endfunction

    function automatic logic [18:0] e_reset(input logic [2:0] imm);
        return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0);
    endfunction

    function automatic logic [18:0] e_decode(input logic [2:0] imm);
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0, 0);
    endfunction

    function automatic logic [18:0] e_trap(input logic [2:0] imm);
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0, 1);
    endfunction

    task automatic push_exp(input string tag, input bit sel, input logic [18:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
    endtask

    task automatic pop_check();
        logic [18:0] e, o;
        string       t;
        bit          s;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        s = sel_q.pop_front();
        o = s ? {mem_req_1, mw_1, irw_1, pcw_1, adr_1, rw_1, rs_1, sa_1, sb_1, aop_1, imm_1, mds_1, ill_1}
              : {mem_req_0, mw_0, irw_0, pcw_0, adr_0, rw_0, rs_0, sa_0, sb_0, aop_0, imm_0, mds_0, ill_0};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (mr mw irw pcw adr rw rs sa sb aop imm mds ill)", t, o, e);
        end
    endtask

    // One FSM cycle: queue expectation, sample at the falling edge, step past the rising edge.
    task automatic cyc(input string tag, input bit sel, input logic [18:0] e);
        push_exp(tag, sel, e);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;

        // Reset state with ready high: strobes must stay low
        op = LW; funct3 = 3'b010; mem_ready = 1'b1;
        push_exp("reset_u0", 0, e_reset(3'b000)); #1; pop_check();
        push_exp("reset_u1", 1, e_reset(3'b000)); #1; pop_check();
        @(posedge clk); #1;

        // lw with three wait cycles in FETCH and one in MEMREAD
        reset0 = 1'b0; mem_ready = 1'b0;
        cyc("lw_fetch_wait0", 0, e_fetch(0, 3'b000));
        cyc("lw_fetch_wait1", 0, e_fetch(0, 3'b000));
        cyc("lw_fetch_wait2", 0, e_fetch(0, 3'b000));
        mem_ready = 1'b1;
        cyc("lw_fetch_ready", 0, e_fetch(1, 3'b000));
        mem_ready = 1'b0;
        cyc("lw_decode", 0, e_decode(3'b000));
        cyc("lw_memadr", 0, ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0));
        cyc("lw_memread_wait", 0, ev(1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        mem_ready = 1'b1;
        cyc("lw_memread_ready", 0, ev(1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        mem_ready = 1'b0;
        cyc("lw_memwb", 0, ev(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));

        // beq not taken, then taken
        op = BR; funct3 = 3'b000; mem_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            br_taken = 1'b0;
            cyc("beq_fetch", 0, e_fetch(1, 3'b010));
            cyc("beq_decode", 0, e_decode(3'b010));
            br_taken = t[0];
            cyc(t == 0 ? "beq_branch_nt" : "beq_branch_t", 0,
                ev(0, 0, 0, t[0], 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 0, 0));
        end
        br_taken = 1'b0;

        // jalr
        op = JLR;
        cyc("jalr_fetch", 0, e_fetch(1, 3'b000));
        cyc("jalr_decode", 0, e_decode(3'b000));
        cyc("jalr_jalra", 0, ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0));
        cyc("jalr_jalrj", 0, ev(0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0, 0));
        cyc("jalr_aluwb", 0, ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));

        // Reset asserted in the middle of a MEMREAD wait
        op = LW; funct3 = 3'b000;
        cyc("rstmid_fetch", 0, e_fetch(1, 3'b000));
        mem_ready = 1'b0;
        cyc("rstmid_decode", 0, e_decode(3'b000));
        cyc("rstmid_memadr", 0, ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0));
        cyc("rstmid_memread", 0, ev(1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        #2 reset0 = 1'b1;
        #1;
        push_exp("rstmid_async", 0, e_reset(3'b000)); pop_check();
        @(posedge clk); #1;
        reset0 = 1'b0;
        cyc("rstmid_refetch", 0, e_fetch(0, 3'b000));

        // Unknown opcode traps and stays trapped
        op = BAD; mem_ready = 1'b1;
        cyc("badop_fetch", 0, e_fetch(1, 3'b000));
        cyc("badop_decode", 0, e_decode(3'b000));
        cyc("badop_trap0", 0, e_trap(3'b000));
        cyc("badop_trap1", 0, e_trap(3'b000));

        // mul without M extension traps
        reset0 = 1'b1; @(posedge clk); #1; reset0 = 1'b0;
        op = RR; funct3 = 3'b000; funct7b0 = 1'b1;
        cyc("mul_noext_fetch", 0, e_fetch(1, 3'b000));
        cyc("mul_noext_decode", 0, e_decode(3'b000));
        cyc("mul_noext_trap0", 0, e_trap(3'b000));
        cyc("mul_noext_trap1", 0, e_trap(3'b000));

        // Store with reserved funct3 traps
        reset0 = 1'b1; @(posedge clk); #1; reset0 = 1'b0;
        op = SW; funct3 = 3'b011; funct7b0 = 1'b0;
        cyc("sw_bad_fetch", 0, e_fetch(1, 3'b001));
        cyc("sw_bad_decode", 0, e_decode(3'b001));
        cyc("sw_bad_trap", 0, e_trap(3'b001));
        reset0 = 1'b1;

        // sw with memory wait disabled: ready input held low and ignored
        reset1 = 1'b0; mem_ready = 1'b0; funct3 = 3'b010;
        cyc("sw_fetch", 1, e_fetch(1, 3'b001));
        cyc("sw_decode", 1, e_decode(3'b001));
        cyc("sw_memadr", 1, ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 0, 0));
        cyc("sw_memwrite", 1, ev(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0));

        // mul with M extension, md_done in the fifth MDEXEC cycle
        op = RR; funct3 = 3'b000; funct7b0 = 1'b1;
        cyc("mul_fetch", 1, e_fetch(1, 3'b000));
        cyc("mul_decode", 1, e_decode(3'b000));
        cyc("mul_mdexec_start", 1, ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        for (int k = 0; k < 4; k++) begin
            if (k == 3) md_done = 1'b1;
            cyc("mul_mdexec_wait", 1, ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        end
        md_done = 1'b0;
        cyc("mul_mdwb", 1, ev(0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));

        // Illegal opcode without trapping returns to FETCH
        op = BAD; funct7b0 = 1'b0;
        cyc("nop_fetch", 1, e_fetch(1, 3'b000));
        cyc("nop_decode", 1, e_decode(3'b000));
        op = RR; funct7b0 = 1'b1;
        cyc("nop_refetch", 1, e_fetch(1, 3'b000));

        // Single-cycle mul/div: md_done together with md_start
        cyc("md1_decode", 1, e_decode(3'b000));
        md_done = 1'b1;
        cyc("md1_mdexec", 1, ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
        md_done = 1'b0;
        cyc("md1_mdwb", 1, ev(0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        cyc("md1_fetch", 1, e_fetch(1, 3'b000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
